// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory request/response path.
//
// Contents:
//   WORD_BYTES    - bytes per storage word (byte lanes per access)
//   dmem_state_t  - responder FSM states: IDLE, WAIT, RESP
//   dmem_req_t    - one latched request: addr, we, wdata, be
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

endpackage

// File: rtl/sram_bank.sv
// Word-addressed storage bank for the data-memory responder.
//
// Writes are byte-enabled. Reads are registered: rdata updates on the
// edge where a read access is enabled and otherwise holds. Contents are
// never reset.
//
// Ports:
//   clk    in   system clock, rising edge
//   en     in   perform an access on this edge
//   we     in   1 = write, 0 = read
//   addr   in   word index
//   wdata  in   write data
//   be     in   byte-lane enables for writes
//   rdata  out  registered read data
module sram_bank
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    input  logic [WORD_BYTES-1:0]          be,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // A write leaves rdata untouched so the last read result is not
    // disturbed; the responder only forwards rdata after a read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port.
//
// Accepts one valid/ready request at a time (word read or byte-enabled
// write), waits LATENCY cycles, performs the access on internal storage
// and presents the result on a response channel that holds until it is
// consumed. Misaligned or out-of-window addresses fault without touching
// storage.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   req_valid   in   request present
//   req_ready   out  responder can accept a request (IDLE only)
//   req_addr    in   byte address
//   req_we      in   1 = write, 0 = read
//   req_wdata   in   write data
//   req_be      in   byte enables for writes
//   resp_valid  out  response present
//   resp_ready  in   requester consumes the response
//   resp_rdata  out  read data, 0 for writes and faults
//   resp_err    out  access fault
module dmem_responder
    import mem_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    dmem_state_t state;
    dmem_req_t   req_buf;
    dmem_req_t   incoming;
    dmem_req_t   access;
    logic [3:0]  count;
    logic        accept;
    logic        do_access;
    logic        access_err;
    logic        rd_ok;
    logic [31:0] offset;
    logic [31:0] sram_rdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With zero latency the access happens on the accepting edge, before
    // the request has reached the buffer, so the live inputs are used
    // while IDLE and the buffered copy otherwise.
    always_comb begin
        incoming       = '0;
        incoming.addr  = req_addr;
        incoming.we    = req_we;
        incoming.wdata = req_wdata;
        incoming.be    = req_be;
        access         = (state == IDLE) ? incoming : req_buf;
    end

    assign do_access = (accept && (LAT == 4'd0)) ||
                       ((state == WAIT) && (count == 4'd1));

    // The offset subtraction wraps for addresses below the window base,
    // which lands them far above SPAN and so flags them as faults.
    assign offset     = access.addr - BASE_ADDR;
    assign access_err = (access.addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);

    // Faulting accesses never reach the bank, so storage is untouched.
    sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .en    (do_access && !access_err),
        .we    (access.we),
        .addr  (offset[AW+1:2]),
        .wdata (access.wdata),
        .be    (access.be),
        .rdata (sram_rdata)
    );

    // Control FSM: accept in IDLE, count down in WAIT, hold in RESP until
    // the handshake. rd_ok records whether the bank's registered output is
    // a valid read result for the pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            req_buf  <= '0;
            resp_err <= 1'b0;
            rd_ok    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_buf <= incoming;
                        count   <= LAT;
                        state   <= (LAT == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state    <= IDLE;
                        resp_err <= 1'b0;
                        rd_ok    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_access) begin
                resp_err <= access_err;
                rd_ok    <= !access.we && !access_err;
            end
        end
    end

    // The bank output only changes on a read access, so gating it with
    // rd_ok yields a response word that is stable until the handshake
    // and zero for writes, faults and outside RESP.
    assign resp_rdata = rd_ok ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
//
// Two instances are exercised: one with LATENCY=2 at base 0, one with
// LATENCY=0 at base 0x1000. A behavioural word-array model predicts
// read data, faults and latency for every transaction.
module tb_dmem_responder;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE_B = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic        req_we     [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem_model [2][DEPTH];
    time         accept_time;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (2),
        .BASE_ADDR  (32'h0000_0000)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_addr   (req_addr[0]),
        .req_we     (req_we[0]),
        .req_wdata  (req_wdata[0]),
        .req_be     (req_be[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (0),
        .BASE_ADDR  (BASE_B)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_addr   (req_addr[1]),
        .req_we     (req_we[1]),
        .req_wdata  (req_wdata[1]),
        .req_be     (req_be[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One complete transaction on instance w, with the response held off
    // for 'hold' cycles before it is consumed.
    task automatic apply_stimulus(input int w, input logic [31:0] addr, input logic we,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input int hold);
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata;
        logic        exp_err;
        logic        got_err;
        int          lat;
        int          cycles;
        int          idx;

        base      = (w == 0) ? 32'h0 : BASE_B;
        lat       = (w == 0) ? 2 : 0;
        off       = addr - base;
        exp_err   = (addr[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
        exp_rdata = 32'h0;
        if (!exp_err) begin
            idx = int'(off >> 2);
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem_model[w][idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                exp_rdata = mem_model[w][idx];
            end
        end

        @(negedge clk);
        req_valid[w] = 1'b1;
        req_addr[w]  = addr;
        req_we[w]    = we;
        req_wdata[w] = wdata;
        req_be[w]    = be;
        check_output("req_ready_idle", 32'(req_ready[w]), 32'd1);

        @(posedge clk);
        accept_time = $time;
        #1;
        req_valid[w] = 1'b0;
        req_addr[w]  = $urandom;
        req_we[w]    = 1'($urandom);
        req_wdata[w] = $urandom;
        req_be[w]    = 4'($urandom);

        cycles = 0;
        while (!resp_valid[w] && cycles < 40) begin
            check_output("req_ready_wait", 32'(req_ready[w]), 32'd0);
            @(posedge clk);
            #1;
            cycles++;
        end
        check_output("latency", 32'(cycles), 32'(lat));

        got_rdata = resp_rdata[w];
        got_err   = resp_err[w];
        check_output("resp_rdata", got_rdata, exp_rdata);
        check_output("resp_err", 32'(got_err), 32'(exp_err));
        check_output("req_ready_resp", 32'(req_ready[w]), 32'd0);

        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check_output("hold_valid", 32'(resp_valid[w]), 32'd1);
            check_output("hold_rdata", resp_rdata[w], exp_rdata);
            check_output("hold_err", 32'(resp_err[w]), 32'(exp_err));
            check_output("hold_req_ready", 32'(req_ready[w]), 32'd0);
        end

        @(negedge clk);
        resp_ready[w] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[w] = 1'b0;
        check_output("post_valid", 32'(resp_valid[w]), 32'd0);
        check_output("post_rdata", resp_rdata[w], 32'h0);
        check_output("post_err", 32'(resp_err[w]), 32'd0);
        check_output("post_req_ready", 32'(req_ready[w]), 32'd1);
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] a;
        time         t_prev;
        int          sel;

        reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            req_valid[w]  = 1'b0;
            req_addr[w]   = 32'h0;
            req_we[w]     = 1'b0;
            req_wdata[w]  = 32'h0;
            req_be[w]     = 4'h0;
            resp_ready[w] = 1'b0;
        end
        #1;
        for (int w = 0; w < 2; w++) begin
            check_output("rst_req_ready", 32'(req_ready[w]), 32'd1);
            check_output("rst_resp_valid", 32'(resp_valid[w]), 32'd0);
            check_output("rst_rdata", resp_rdata[w], 32'h0);
            check_output("rst_err", 32'(resp_err[w]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;

        $display("[TB] filling the low 32 words of both instances");
        for (int w = 0; w < 2; w++) begin
            base = (w == 0) ? 32'h0 : BASE_B;
            for (int i = 0; i < 32; i++) begin
                apply_stimulus(w, base + 32'(i * 4), 1'b1, $urandom, 4'hF, 0);
            end
        end

        $display("[TB] directed sequence, LATENCY=2");
        apply_stimulus(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0);
        apply_stimulus(0, 32'h10, 1'b0, 32'h0, 4'h0, 0);
        apply_stimulus(0, 32'h10, 1'b1, 32'h0000AB00, 4'b0010, 0);
        apply_stimulus(0, 32'h10, 1'b0, 32'h0, 4'hF, 0);
        apply_stimulus(0, 32'h13, 1'b0, 32'h0, 4'h0, 0);
        apply_stimulus(0, 32'(DEPTH * 4), 1'b0, 32'h0, 4'h0, 0);
        apply_stimulus(0, 32'hFFFF_FFFC, 1'b1, 32'h1, 4'hF, 0);
        apply_stimulus(0, 32'h10, 1'b0, 32'h0, 4'h0, 5);

        $display("[TB] reset during WAIT of a write");
        apply_stimulus(0, 32'h20, 1'b1, 32'hCAFEF00D, 4'hF, 0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check_output("wait_req_ready", 32'(req_ready[0]), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_req_ready", 32'(req_ready[0]), 32'd1);
        check_output("midrst_valid", 32'(resp_valid[0]), 32'd0);
        check_output("midrst_rdata", resp_rdata[0], 32'h0);
        check_output("midrst_err", 32'(resp_err[0]), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check_output("midrst_no_resp", 32'(resp_valid[0]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(0, 32'h20, 1'b0, 32'h0, 4'h0, 0);

        $display("[TB] directed sequence, LATENCY=0");
        apply_stimulus(1, BASE_B + 32'h10, 1'b1, 32'hA5A5_5A5A, 4'hF, 0);
        apply_stimulus(1, BASE_B + 32'h10, 1'b0, 32'h0, 4'h0, 0);
        apply_stimulus(1, BASE_B - 32'h4, 1'b0, 32'h0, 4'h0, 0);
        apply_stimulus(1, BASE_B + 32'(DEPTH * 4), 1'b0, 32'h0, 4'h0, 0);
        apply_stimulus(1, BASE_B + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0, 0);
        apply_stimulus(1, BASE_B + 32'h10, 1'b0, 32'h0, 4'h0, 2);
        apply_stimulus(1, BASE_B + 32'h14, 1'b0, 32'h0, 4'h0, 0);
        t_prev = accept_time;
        apply_stimulus(1, BASE_B + 32'h18, 1'b0, 32'h0, 4'h0, 0);
        check_output("b2b_interval", 32'(accept_time - t_prev), 32'd20);

        $display("[TB] randomized traffic");
        for (int w = 0; w < 2; w++) begin
            base = (w == 0) ? 32'h0 : BASE_B;
            for (int n = 0; n < 60; n++) begin
                sel = int'($urandom_range(0, 9));
                a   = base + ($urandom_range(0, 31) << 2);
                if (sel == 0) begin
                    a = a + $urandom_range(1, 3);
                end else if (sel == 1) begin
                    a = base + 32'(DEPTH * 4) + ($urandom_range(0, 15) << 2);
                end else if (sel == 2) begin
                    a = base - 32'h4;
                end
                apply_stimulus(w, a, 1'($urandom), $urandom, 4'($urandom),
                               int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
